ct_f_spsram_bwen_rmw: RTL and testbench
=======================================

Name: ct_f_spsram_bwen_rmw

Overview:
- Parametrised FPGA single-port SRAM wrapper that replaces the fixed-size, WEN[0]-only wrappers.
- Honours the full per-bit write mask by running an internal read-modify-write (RMW) sequence over a plain single-port FPGA RAM array.
- Presents the standard macro-style interface (A/CEN/D/GWEN/WEN/Q) plus a BUSY stall output.
- Used for all FPGA-build tag/data/status arrays that need partial-bit writes.

Parameters:
- DATA_WIDTH, 23, word width in bits for D, Q and WEN.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- A  input  ADDR_WIDTH  access address.
- CEN  input  1  chip enable, active low.
- D  input  DATA_WIDTH  write data.
- GWEN  input  1  global write enable, active low (0 = write, 1 = read).
- WEN  input  DATA_WIDTH  per-bit write enable, active low (0 = write that bit).
- Q  output  DATA_WIDTH  read data, registered.
- BUSY  output  1  high while an RMW write-back is in progress; requests are not accepted.

Behaviour:
- Reset (RST=1 at a clock edge):
  - State goes to IDLE; Q=0, BUSY=0, held address=0, RMW holding registers=0.
  - Array contents are not initialised.
  - Reset takes priority over any access in the same cycle.
- Access acceptance: a request is accepted at the edge where CEN=0, BUSY=0 and RST=0. When BUSY=1, CEN/A/D/GWEN/WEN are ignored entirely.
- States:
  - IDLE: accepts requests.
  - RMW_WB: one cycle, merge and write-back.
- Read (GWEN=1):
  - Q = mem[A] on the edge after acceptance (1-cycle latency).
  - Q holds its value on every cycle with no accepted read, including writes, idle cycles and BUSY cycles.
- Full write (GWEN=0, WEN all 0):
  - mem[A] = D at the acceptance edge; single cycle; BUSY stays 0.
- Null write (GWEN=0, WEN all 1): no array change, no state change; treated as idle.
- Partial write (GWEN=0, WEN mixed):
  - Cycle 0 (accept): array read of A; latch A, D and WEN; go to RMW_WB; BUSY=1 from the next cycle.
  - Cycle 1 (RMW_WB): merged = (old & WEN) | (D & ~WEN); write merged to latched address; return to IDLE. BUSY returns to 0 after this edge.
  - Back-to-back throughput for partial writes is one per 2 cycles.
- Address holding:
  - The address fed to the array is A when CEN=0, otherwise the last accepted address.
  - During RMW_WB the latched RMW address is used.
- Read-after-write ordering:
  - A read accepted the cycle after a full write to the same address returns the new data.
  - A read accepted the cycle after RMW_WB completes returns the merged data.
- Reset during RMW_WB: the write-back is dropped, the array is unchanged, and the state returns to IDLE with BUSY=0.
- Out-of-range: none; every A value addresses a valid word (depth is a power of 2).
- Widths: WEN and D are exactly DATA_WIDTH; there is no truncation or extension inside the block.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, then CEN=1 -> Q=0 and BUSY=0 throughout.
- Full write then read: write A=0x05, D=0x7FFFFF, WEN=0; next cycle read A=0x05 -> Q=0x7FFFFF one cycle later; Q is unchanged during the write cycle.
- Partial write:
  - Preload mem[0x10]=0x000000.
  - Write D=0x7FFFFF, WEN=0x7FFF00 (low byte enabled) -> BUSY=1 for exactly one cycle.
  - Subsequent read of 0x10 -> Q=0x0000FF.
- BUSY blocking:
  - Issue a partial write to 0x20, then drive a full write D=0x123456 to 0x21 while BUSY=1.
  - Required: mem[0x21] unchanged, and only the 0x20 merge is visible on readback.
- Reset mid-RMW:
  - Preload mem[0x30]=0x0000AA; partial write D=0x000055, WEN=0x7FFF0F.
  - Assert RST in the RMW_WB cycle -> mem[0x30] reads back 0x0000AA, and BUSY=0 after reset.
- Null write and Q hold:
  - Read 0x05 (Q=0x7FFFFF), then issue GWEN=0, WEN all 1, D=0 to 0x05, then CEN=1 for 3 cycles.
  - Required: Q stays 0x7FFFFF; a re-read of 0x05 returns 0x7FFFFF.

Source files
------------

// File: rtl/ct_f_spsram_bwen_rmw.sv
// ct_f_spsram_bwen_rmw
//   Single-port SRAM wrapper for FPGA builds with a full per-bit write mask.
//   A plain single-port RAM array is wrapped so that partial-bit writes are
//   performed as a two-cycle read-modify-write; BUSY stalls the requester
//   during the write-back cycle.
//
// Ports
//   CLK   in   1           clock, rising edge
//   RST   in   1           synchronous reset, active high
//   A     in   ADDR_WIDTH  access address
//   CEN   in   1           chip enable, active low
//   D     in   DATA_WIDTH  write data
//   GWEN  in   1           global write enable, active low (1 = read)
//   WEN   in   DATA_WIDTH  per-bit write enable, active low
//   Q     out  DATA_WIDTH  registered read data
//   BUSY  out  1           RMW write-back in progress, requests ignored
module ct_f_spsram_bwen_rmw #(
  parameter int DATA_WIDTH = 23,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WB = 1'b1
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  // Accept-stage signals
  logic [ADDR_WIDTH-1:0]   addr_hold;
  logic [ADDR_WIDTH-1:0]   mem_addr_p0;
  logic                    acc_p0;
  logic                    rd_p0;
  logic                    wr_full_p0;
  logic                    wr_part_p0;

  // Write-back-stage holding registers
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [DATA_WIDTH-1:0]   d_p1;
  logic [DATA_WIDTH-1:0]   wen_p1;
  logic [DATA_WIDTH-1:0]   old_p1;
  logic                    vld_p1;

  // Keep old bits where WEN=1, take D where WEN=0.
  function automatic logic [DATA_WIDTH-1:0] rmw_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [DATA_WIDTH-1:0] wen_n
  );
    return (old_w & wen_n) | (new_w & ~wen_n);
  endfunction

  // ---- p0: request acceptance and array address selection ----
  always_comb begin
    acc_p0     = !CEN && (state == IDLE);
    rd_p0      = acc_p0 && GWEN;
    wr_full_p0 = acc_p0 && !GWEN && (WEN == '0);
    // An all-ones mask is a null write and is deliberately not decoded here.
    wr_part_p0 = acc_p0 && !GWEN && (WEN != '0) && (WEN != '1);
    if (state == RMW_WB)
      mem_addr_p0 = addr_p1;
    else if (!CEN)
      mem_addr_p0 = A;
    else
      mem_addr_p0 = addr_hold;
  end

  // Array write port. The write-back is suppressed under reset so a reset
  // landing in RMW_WB leaves the array untouched.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (vld_p1)
        mem[mem_addr_p0] <= rmw_merge(old_p1, d_p1, wen_p1);
      else if (wr_full_p0)
        mem[mem_addr_p0] <= D;
    end
  end

  // Control FSM, read register and RMW holding registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      Q         <= '0;
      BUSY      <= 1'b0;
      addr_hold <= '0;
      addr_p1   <= '0;
      d_p1      <= '0;
      wen_p1    <= '0;
      old_p1    <= '0;
      vld_p1    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_p0)
            addr_hold <= A;
          if (rd_p0)
            Q <= mem[mem_addr_p0];
          if (wr_part_p0) begin
            old_p1 <= mem[mem_addr_p0];
            addr_p1 <= A;
            d_p1    <= D;
            wen_p1  <= WEN;
            vld_p1  <= 1'b1;
            BUSY    <= 1'b1;
            state   <= RMW_WB;
          end
        end
        // ---- p1: merge and write-back, back to IDLE ----
        RMW_WB: begin
          vld_p1 <= 1'b0;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          vld_p1 <= 1'b0;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ct_f_spsram_bwen_rmw.sv
// tb_ct_f_spsram_bwen_rmw
//   Directed, table-driven bench for ct_f_spsram_bwen_rmw with hand-written
//   sequences for reset during write-back.
module tb_ct_f_spsram_bwen_rmw;

  localparam int DW = 23;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] A;
  logic          CEN;
  logic [DW-1:0] D;
  logic          GWEN;
  logic [DW-1:0] WEN;
  logic [DW-1:0] Q;
  logic          BUSY;

  int n_vec  = 0;
  int n_fail = 0;

  ct_f_spsram_bwen_rmw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .A   (A),
    .CEN (CEN),
    .D   (D),
    .GWEN(GWEN),
    .WEN (WEN),
    .Q   (Q),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string         name;
    logic          rst;
    logic          cen;
    logic [AW-1:0] a;
    logic          gwen;
    logic [DW-1:0] wen;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_q;
    logic          exp_busy;
  } vec_t;

  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] ZERO = '0;

  vec_t vt [$];

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic rst, input logic cen, input logic [AW-1:0] a,
                      input logic gwen, input logic [DW-1:0] wen,
                      input logic [DW-1:0] d);
    RST = rst; CEN = cen; A = a; GWEN = gwen; WEN = wen; D = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] exp_q,
                       input logic exp_busy);
    n_vec++;
    if (Q !== exp_q || BUSY !== exp_busy) begin
      n_fail++;
      $display("FAIL %s: Q=%06h BUSY=%0b, required Q=%06h BUSY=%0b",
               name, Q, BUSY, exp_q, exp_busy);
    end
  endtask

  initial begin
    RST = 1'b1; CEN = 1'b1; A = '0; GWEN = 1'b1; WEN = ONES; D = '0;
    #2;

    //         name            rst  cen  a      gwen wen        d          exp_q      busy
    vt.push_back('{"rst0",      1'b1,1'b1,8'h00,1'b1,ONES,      ZERO,      23'h000000,1'b0});
    vt.push_back('{"rst1",      1'b1,1'b1,8'h00,1'b1,ONES,      ZERO,      23'h000000,1'b0});
    vt.push_back('{"idle0",     1'b0,1'b1,8'h00,1'b1,ONES,      ZERO,      23'h000000,1'b0});
    vt.push_back('{"idle1",     1'b0,1'b1,8'h00,1'b1,ONES,      ZERO,      23'h000000,1'b0});
    // Full write then read-after-write
    vt.push_back('{"wr05",      1'b0,1'b0,8'h05,1'b0,ZERO,      23'h7FFFFF,23'h000000,1'b0});
    vt.push_back('{"rd05",      1'b0,1'b0,8'h05,1'b1,ONES,      ZERO,      23'h7FFFFF,1'b0});
    // Partial write of low byte into a zeroed word
    vt.push_back('{"pre10",     1'b0,1'b0,8'h10,1'b0,ZERO,      ZERO,      23'h7FFFFF,1'b0});
    vt.push_back('{"pw10",      1'b0,1'b0,8'h10,1'b0,23'h7FFF00,23'h7FFFFF,23'h7FFFFF,1'b1});
    vt.push_back('{"pw10_wb",   1'b0,1'b1,8'h00,1'b1,ONES,      ZERO,      23'h7FFFFF,1'b0});
    vt.push_back('{"rd10",      1'b0,1'b0,8'h10,1'b1,ONES,      ZERO,      23'h0000FF,1'b0});
    // Null write and Q hold
    vt.push_back('{"rd05b",     1'b0,1'b0,8'h05,1'b1,ONES,      ZERO,      23'h7FFFFF,1'b0});
    vt.push_back('{"null05",    1'b0,1'b0,8'h05,1'b0,ONES,      ZERO,      23'h7FFFFF,1'b0});
    vt.push_back('{"hold0",     1'b0,1'b1,8'h00,1'b1,ONES,      ZERO,      23'h7FFFFF,1'b0});
    vt.push_back('{"hold1",     1'b0,1'b1,8'h00,1'b1,ONES,      ZERO,      23'h7FFFFF,1'b0});
    vt.push_back('{"hold2",     1'b0,1'b1,8'h00,1'b1,ONES,      ZERO,      23'h7FFFFF,1'b0});
    vt.push_back('{"rd05c",     1'b0,1'b0,8'h05,1'b1,ONES,      ZERO,      23'h7FFFFF,1'b0});
    // BUSY blocking: write to 0x21 during write-back must be ignored
    vt.push_back('{"pre20",     1'b0,1'b0,8'h20,1'b0,ZERO,      ZERO,      23'h7FFFFF,1'b0});
    vt.push_back('{"pre21",     1'b0,1'b0,8'h21,1'b0,ZERO,      ZERO,      23'h7FFFFF,1'b0});
    vt.push_back('{"pw20",      1'b0,1'b0,8'h20,1'b0,23'h7FFFF0,23'h7FFFFF,23'h7FFFFF,1'b1});
    vt.push_back('{"blk21",     1'b0,1'b0,8'h21,1'b0,ZERO,      23'h123456,23'h7FFFFF,1'b0});
    vt.push_back('{"rd21",      1'b0,1'b0,8'h21,1'b1,ONES,      ZERO,      23'h000000,1'b0});
    vt.push_back('{"rd20",      1'b0,1'b0,8'h20,1'b1,ONES,      ZERO,      23'h00000F,1'b0});
    // Read during BUSY is ignored; merge applies over previous merge
    vt.push_back('{"pw20b",     1'b0,1'b0,8'h20,1'b0,23'h7FFFFE,ZERO,      23'h00000F,1'b1});
    vt.push_back('{"blkrd05",   1'b0,1'b0,8'h05,1'b1,ONES,      ZERO,      23'h00000F,1'b0});
    vt.push_back('{"rd20b",     1'b0,1'b0,8'h20,1'b1,ONES,      ZERO,      23'h00000E,1'b0});
    // Back-to-back partial writes, one per two cycles
    vt.push_back('{"pwA",       1'b0,1'b0,8'h10,1'b0,23'h7FF0FF,23'h00AB00,23'h00000E,1'b1});
    vt.push_back('{"pwA_wb",    1'b0,1'b1,8'h00,1'b1,ONES,      ZERO,      23'h00000E,1'b0});
    vt.push_back('{"pwB",       1'b0,1'b0,8'h10,1'b0,23'h00FFFF,23'h550000,23'h00000E,1'b1});
    vt.push_back('{"pwB_wb",    1'b0,1'b1,8'h00,1'b1,ONES,      ZERO,      23'h00000E,1'b0});
    vt.push_back('{"rd10b",     1'b0,1'b0,8'h10,1'b1,ONES,      ZERO,      23'h550BFF,1'b0});

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].cen, vt[i].a, vt[i].gwen, vt[i].wen, vt[i].d);
      check(vt[i].name, vt[i].exp_q, vt[i].exp_busy);
    end

    // Reset landing in the write-back cycle drops the merge.
    step(1'b0, 1'b0, 8'h30, 1'b0, ZERO, 23'h0000AA);
    check("pre30", 23'h550BFF, 1'b0);
    step(1'b0, 1'b0, 8'h30, 1'b0, 23'h7FFF0F, 23'h000055);
    check("pw30", 23'h550BFF, 1'b1);
    step(1'b1, 1'b1, 8'h00, 1'b1, ONES, ZERO);
    check("rst_wb", 23'h000000, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b1, ONES, ZERO);
    check("post_rst", 23'h000000, 1'b0);
    step(1'b0, 1'b0, 8'h30, 1'b1, ONES, ZERO);
    check("rd30", 23'h0000AA, 1'b0);

    // Reset also beats a full write in the same cycle.
    step(1'b1, 1'b0, 8'h30, 1'b0, ZERO, 23'h111111);
    check("rst_wr", 23'h000000, 1'b0);
    step(1'b0, 1'b0, 8'h30, 1'b1, ONES, ZERO);
    check("rd30b", 23'h0000AA, 1'b0);

    // Read accepted right after a merge write-back sees the merged word.
    step(1'b0, 1'b0, 8'h30, 1'b0, 23'h7FFF0F, 23'h000055);
    check("pw30b", 23'h0000AA, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1, ONES, ZERO);
    check("pw30b_wb", 23'h0000AA, 1'b0);
    step(1'b0, 1'b0, 8'h30, 1'b1, ONES, ZERO);
    check("rd30c", 23'h00005A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
